// File: rtl/river_axi_pkg.sv
// Shared AXI4 channel definitions and River L1 memory-port encodings
// used by the L1-to-AXI memory bridge.
package river_axi_pkg;

    localparam int CFG_CPU_ADDR_BITS = 48;
    localparam int L1CACHE_LINE_BITS = 256;
    localparam int AXI_DATA_BITS     = 64;
    localparam int AXI_STRB_BITS     = AXI_DATA_BITS / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_8B     = 3'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int REQ_MEM_TYPE_WRITE  = 0;
    localparam int REQ_MEM_TYPE_CACHED = 1;
    localparam int REQ_MEM_TYPE_UNIQUE = 2;

    typedef struct packed {
        logic [CFG_CPU_ADDR_BITS-1:0] addr;
        logic [7:0]                   len;
        logic [2:0]                   size;
        logic [1:0]                   burst;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [CFG_CPU_ADDR_BITS-1:0] addr;
        logic [7:0]                   len;
        logic [2:0]                   size;
        logic [1:0]                   burst;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [AXI_DATA_BITS-1:0] data;
        logic [AXI_STRB_BITS-1:0] strb;
        logic                     last;
    } axi_w_chan_t;

    typedef struct packed {
        logic [AXI_DATA_BITS-1:0] data;
        logic [1:0]               resp;
        logic                     last;
    } axi_r_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } axi_b_chan_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_RESP
    } bridge_state_t;

endpackage

// File: rtl/river_mem_axi_bridge.sv
// River L1 memory port to AXI4 master bridge: one line burst or one uncached
// beat in flight, read beats gathered into a single line-wide response pulse.
module river_mem_axi_bridge
    import river_axi_pkg::*;
#(
    parameter int abits     = CFG_CPU_ADDR_BITS,
    parameter int line_bits = L1CACHE_LINE_BITS,
    parameter int beats     = line_bits / AXI_DATA_BITS
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_mem_valid,
    output logic                   o_req_mem_ready,
    input  logic                   i_req_mem_path,
    input  logic [2:0]             i_req_mem_type,
    input  logic [2:0]             i_req_mem_size,
    input  logic [abits-1:0]       i_req_mem_addr,
    input  logic [line_bits/8-1:0] i_req_mem_strob,
    input  logic [line_bits-1:0]   i_req_mem_data,
    output logic                   o_resp_mem_valid,
    output logic                   o_resp_mem_path,
    output logic [line_bits-1:0]   o_resp_mem_data,
    output logic                   o_resp_mem_load_fault,
    output logic                   o_resp_mem_store_fault,
    output logic                   o_ar_valid,
    input  logic                   i_ar_ready,
    output logic [abits-1:0]       o_ar_addr,
    output logic [7:0]             o_ar_len,
    output logic [2:0]             o_ar_size,
    output logic [1:0]             o_ar_burst,
    input  logic                   i_r_valid,
    output logic                   o_r_ready,
    input  logic [63:0]            i_r_data,
    input  logic [1:0]             i_r_resp,
    input  logic                   i_r_last,
    output logic                   o_aw_valid,
    input  logic                   i_aw_ready,
    output logic [abits-1:0]       o_aw_addr,
    output logic [7:0]             o_aw_len,
    output logic [2:0]             o_aw_size,
    output logic [1:0]             o_aw_burst,
    output logic                   o_w_valid,
    input  logic                   i_w_ready,
    output logic [63:0]            o_w_data,
    output logic [7:0]             o_w_strb,
    output logic                   o_w_last,
    input  logic                   i_b_valid,
    output logic                   o_b_ready,
    input  logic [1:0]             i_b_resp
);

    bridge_state_t state, state_next;

    logic [abits-1:0]       req_addr;
    logic [2:0]             req_size;
    logic                   req_cached;
    logic                   req_path;
    logic [line_bits/8-1:0] req_strob;
    logic [line_bits-1:0]   req_data;
    logic [line_bits-1:0]   rd_line;
    logic                   load_fault;
    logic                   store_fault;
    logic [1:0]             beat_cnt;
    logic [1:0]             lane;

    logic req_fire, ar_fire, aw_fire, r_fire, w_fire, b_fire;

    axi_ar_chan_t ar_chan;
    axi_aw_chan_t aw_chan;
    axi_w_chan_t  w_chan;
    axi_r_chan_t  r_chan;
    axi_b_chan_t  b_chan;

    logic unused_bits;

    function automatic logic [63:0] lane_get(input logic [line_bits-1:0] line,
                                             input logic [1:0]           idx);
        return line[{idx, 6'b0} +: 64];
    endfunction

    function automatic logic [line_bits-1:0] lane_put(input logic [line_bits-1:0] line,
                                                      input logic [1:0]           idx,
                                                      input logic [63:0]          word);
        logic [line_bits-1:0] res;
        res = line;
        res[{idx, 6'b0} +: 64] = word;
        return res;
    endfunction

    assign r_chan = '{data: i_r_data, resp: i_r_resp, last: i_r_last};
    assign b_chan = '{resp: i_b_resp};

    assign req_fire = i_req_mem_valid & o_req_mem_ready;
    assign ar_fire  = o_ar_valid & i_ar_ready;
    assign aw_fire  = o_aw_valid & i_aw_ready;
    assign r_fire   = i_r_valid & o_r_ready;
    assign w_fire   = o_w_valid & i_w_ready;
    assign b_fire   = i_b_valid & o_b_ready;

    // Line bursts walk the lanes with the beat counter; a single uncached
    // beat always lives in the lane picked by the address.
    assign lane = req_cached ? beat_cnt : req_addr[4:3];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_fire) begin
                    state_next = i_req_mem_type[REQ_MEM_TYPE_WRITE] ? ST_AW : ST_AR;
                end
            end
            ST_AR:   if (ar_fire) state_next = ST_R;
            ST_R:    if (r_fire && r_chan.last) state_next = ST_RESP;
            ST_AW:   if (aw_fire) state_next = ST_W;
            ST_W:    if (w_fire && w_chan.last) state_next = ST_B;
            ST_B:    if (b_fire) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_mem_ready  = 1'b0;
        o_ar_valid       = 1'b0;
        o_r_ready        = 1'b0;
        o_aw_valid       = 1'b0;
        o_w_valid        = 1'b0;
        o_b_ready        = 1'b0;
        o_resp_mem_valid = 1'b0;
        case (state)
            ST_IDLE: o_req_mem_ready  = 1'b1;
            ST_AR:   o_ar_valid       = 1'b1;
            ST_R:    o_r_ready        = 1'b1;
            ST_AW:   o_aw_valid       = 1'b1;
            ST_W:    o_w_valid        = 1'b1;
            ST_B:    o_b_ready        = 1'b1;
            ST_RESP: o_resp_mem_valid = 1'b1;
            default: o_req_mem_ready  = 1'b0;
        endcase
    end

    // Address channels are built only from latched request fields so the
    // payload cannot move while valid is waiting for ready.
    always_comb begin
        ar_chan.addr  = req_cached ? {req_addr[abits-1:5], 5'b0} : req_addr;
        ar_chan.len   = req_cached ? 8'(beats - 1) : 8'd0;
        ar_chan.size  = req_cached ? SIZE_8B : req_size;
        ar_chan.burst = BURST_INCR;
        aw_chan.addr  = ar_chan.addr;
        aw_chan.len   = ar_chan.len;
        aw_chan.size  = ar_chan.size;
        aw_chan.burst = ar_chan.burst;
        w_chan.data   = lane_get(req_data, lane);
        w_chan.strb   = req_strob[{lane, 3'b0} +: 8];
        w_chan.last   = req_cached ? (beat_cnt == 2'(beats - 1)) : 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_addr    <= '0;
            req_size    <= '0;
            req_cached  <= 1'b0;
            req_path    <= 1'b0;
            req_strob   <= '0;
            req_data    <= '0;
            rd_line     <= '0;
            load_fault  <= 1'b0;
            store_fault <= 1'b0;
            beat_cnt    <= '0;
        end else begin
            if (req_fire) begin
                req_addr    <= i_req_mem_addr;
                req_size    <= i_req_mem_size;
                req_cached  <= i_req_mem_type[REQ_MEM_TYPE_CACHED];
                req_path    <= i_req_mem_path;
                req_strob   <= i_req_mem_strob;
                req_data    <= i_req_mem_data;
                rd_line     <= '0;
                load_fault  <= 1'b0;
                store_fault <= 1'b0;
                beat_cnt    <= '0;
            end
            if (r_fire) begin
                rd_line    <= lane_put(rd_line, lane, r_chan.data);
                load_fault <= load_fault | r_chan.resp[1];
                beat_cnt   <= beat_cnt + 2'd1;
            end
            if (w_fire) begin
                beat_cnt <= beat_cnt + 2'd1;
            end
            if (b_fire) begin
                store_fault <= b_chan.resp[1];
            end
        end
    end

    assign o_ar_addr  = ar_chan.addr;
    assign o_ar_len   = ar_chan.len;
    assign o_ar_size  = ar_chan.size;
    assign o_ar_burst = ar_chan.burst;

    assign o_aw_addr  = aw_chan.addr;
    assign o_aw_len   = aw_chan.len;
    assign o_aw_size  = aw_chan.size;
    assign o_aw_burst = aw_chan.burst;

    assign o_w_data = w_chan.data;
    assign o_w_strb = w_chan.strb;
    assign o_w_last = w_chan.last;

    assign o_resp_mem_path        = req_path;
    assign o_resp_mem_data        = rd_line;
    assign o_resp_mem_load_fault  = load_fault;
    assign o_resp_mem_store_fault = store_fault;

    // OKAY and EXOKAY differ only in bit 0, which never signals a fault.
    assign unused_bits = ^{i_req_mem_type[REQ_MEM_TYPE_UNIQUE], r_chan.resp[0], b_chan.resp[0]};

endmodule

// File: tb/tb_river_mem_axi_bridge.sv
// Directed bench for river_mem_axi_bridge: a table of request/slave-behaviour
// vectors plus hand-written back-to-back and mid-burst reset sequences.
module tb_river_mem_axi_bridge;
    import river_axi_pkg::*;

    localparam int NVEC = 7;

    logic         i_clk;
    logic         i_rst;
    logic         i_req_mem_valid;
    logic         o_req_mem_ready;
    logic         i_req_mem_path;
    logic [2:0]   i_req_mem_type;
    logic [2:0]   i_req_mem_size;
    logic [47:0]  i_req_mem_addr;
    logic [31:0]  i_req_mem_strob;
    logic [255:0] i_req_mem_data;
    logic         o_resp_mem_valid;
    logic         o_resp_mem_path;
    logic [255:0] o_resp_mem_data;
    logic         o_resp_mem_load_fault;
    logic         o_resp_mem_store_fault;
    logic         o_ar_valid;
    logic         i_ar_ready;
    logic [47:0]  o_ar_addr;
    logic [7:0]   o_ar_len;
    logic [2:0]   o_ar_size;
    logic [1:0]   o_ar_burst;
    logic         i_r_valid;
    logic         o_r_ready;
    logic [63:0]  i_r_data;
    logic [1:0]   i_r_resp;
    logic         i_r_last;
    logic         o_aw_valid;
    logic         i_aw_ready;
    logic [47:0]  o_aw_addr;
    logic [7:0]   o_aw_len;
    logic [2:0]   o_aw_size;
    logic [1:0]   o_aw_burst;
    logic         o_w_valid;
    logic         i_w_ready;
    logic [63:0]  o_w_data;
    logic [7:0]   o_w_strb;
    logic         o_w_last;
    logic         i_b_valid;
    logic         o_b_ready;
    logic [1:0]   i_b_resp;

    int checks;
    int errors;

    typedef struct {
        logic             write;
        logic             cached;
        logic             path;
        logic [2:0]       size;
        logic [47:0]      addr;
        logic [31:0]      strob;
        logic [255:0]     wdata;
        int               n_rbeats;
        logic [3:0][63:0] rbeat;
        logic [3:0][1:0]  rresp;
        logic [1:0]       bresp;
        logic             wtoggle;
        logic [47:0]      exp_addr;
        logic [7:0]       exp_len;
        logic [2:0]       exp_size;
        int               exp_wbeats;
        logic [3:0][63:0] exp_wdata;
        logic [3:0][7:0]  exp_strb;
        logic [255:0]     exp_data;
        logic             exp_load_fault;
        logic             exp_store_fault;
        int               exp_cycles;
    } vec_t;

    vec_t vecs[NVEC];

    river_mem_axi_bridge dut (
        .i_clk                  (i_clk),
        .i_rst                  (i_rst),
        .i_req_mem_valid        (i_req_mem_valid),
        .o_req_mem_ready        (o_req_mem_ready),
        .i_req_mem_path         (i_req_mem_path),
        .i_req_mem_type         (i_req_mem_type),
        .i_req_mem_size         (i_req_mem_size),
        .i_req_mem_addr         (i_req_mem_addr),
        .i_req_mem_strob        (i_req_mem_strob),
        .i_req_mem_data         (i_req_mem_data),
        .o_resp_mem_valid       (o_resp_mem_valid),
        .o_resp_mem_path        (o_resp_mem_path),
        .o_resp_mem_data        (o_resp_mem_data),
        .o_resp_mem_load_fault  (o_resp_mem_load_fault),
        .o_resp_mem_store_fault (o_resp_mem_store_fault),
        .o_ar_valid             (o_ar_valid),
        .i_ar_ready             (i_ar_ready),
        .o_ar_addr              (o_ar_addr),
        .o_ar_len               (o_ar_len),
        .o_ar_size              (o_ar_size),
        .o_ar_burst             (o_ar_burst),
        .i_r_valid              (i_r_valid),
        .o_r_ready              (o_r_ready),
        .i_r_data               (i_r_data),
        .i_r_resp               (i_r_resp),
        .i_r_last               (i_r_last),
        .o_aw_valid             (o_aw_valid),
        .i_aw_ready             (i_aw_ready),
        .o_aw_addr              (o_aw_addr),
        .o_aw_len               (o_aw_len),
        .o_aw_size              (o_aw_size),
        .o_aw_burst             (o_aw_burst),
        .o_w_valid              (o_w_valid),
        .i_w_ready              (i_w_ready),
        .o_w_data               (o_w_data),
        .o_w_strb               (o_w_strb),
        .o_w_last               (o_w_last),
        .i_b_valid              (i_b_valid),
        .o_b_ready              (o_b_ready),
        .i_b_resp               (i_b_resp)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clearSlave();
        i_ar_ready = 1'b0;
        i_aw_ready = 1'b0;
        i_w_ready  = 1'b0;
        i_r_valid  = 1'b0;
        i_r_data   = '0;
        i_r_resp   = RESP_OKAY;
        i_r_last   = 1'b0;
        i_b_valid  = 1'b0;
        i_b_resp   = RESP_OKAY;
    endtask

    // Zero-wait slave answering single-beat reads and any write.
    task automatic slaveStep(input logic [63:0] rd);
        clearSlave();
        i_ar_ready = 1'b1;
        i_aw_ready = 1'b1;
        i_w_ready  = 1'b1;
        i_r_valid  = o_r_ready;
        i_r_data   = rd;
        i_r_last   = 1'b1;
        i_b_valid  = o_b_ready;
    endtask

    function automatic vec_t blankVec();
        vec_t v;
        v.write = 0; v.cached = 0; v.path = 0; v.size = 0; v.addr = 0;
        v.strob = 0; v.wdata = 0; v.n_rbeats = 0; v.rbeat = 0; v.rresp = 0;
        v.bresp = 0; v.wtoggle = 0; v.exp_addr = 0; v.exp_len = 0; v.exp_size = 0;
        v.exp_wbeats = 0; v.exp_wdata = 0; v.exp_strb = 0; v.exp_data = 0;
        v.exp_load_fault = 0; v.exp_store_fault = 0; v.exp_cycles = 0;
        return v;
    endfunction

    task automatic fillVectors();
        for (int i = 0; i < NVEC; i++) vecs[i] = blankVec();
        // 0: cached line read, unaligned address, zero-wait slave
        vecs[0].cached = 1; vecs[0].path = 1; vecs[0].size = 3; vecs[0].addr = 48'h1000_0024;
        vecs[0].n_rbeats = 4;
        vecs[0].rbeat = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        vecs[0].exp_addr = 48'h1000_0020; vecs[0].exp_len = 3; vecs[0].exp_size = 3;
        vecs[0].exp_data = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        vecs[0].exp_cycles = 7;
        // 1: cached line write, w_ready toggling
        vecs[1].write = 1; vecs[1].cached = 1; vecs[1].path = 1; vecs[1].size = 3;
        vecs[1].addr = 48'h2000_0047; vecs[1].strob = 32'hFFFF_00FF; vecs[1].wtoggle = 1;
        vecs[1].wdata = {64'hD3D3_D3D3_D3D3_D3D3, 64'hC2C2_C2C2_C2C2_C2C2,
                         64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0};
        vecs[1].exp_addr = 48'h2000_0040; vecs[1].exp_len = 3; vecs[1].exp_size = 3;
        vecs[1].exp_wbeats = 4;
        vecs[1].exp_wdata = {64'hD3D3_D3D3_D3D3_D3D3, 64'hC2C2_C2C2_C2C2_C2C2,
                             64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0};
        vecs[1].exp_strb = {8'hFF, 8'hFF, 8'h00, 8'hFF};
        vecs[1].exp_cycles = 12;
        // 2: uncached 4-byte read landing in lane 3
        vecs[2].size = 2; vecs[2].addr = 48'h18; vecs[2].n_rbeats = 1;
        vecs[2].rbeat = {192'h0, 64'h0000_0000_DEAD_BEEF};
        vecs[2].exp_addr = 48'h18; vecs[2].exp_len = 0; vecs[2].exp_size = 2;
        vecs[2].exp_data = {64'h0000_0000_DEAD_BEEF, 192'h0};
        vecs[2].exp_cycles = 4;
        // 3: cached read with SLVERR on beat 1 only
        vecs[3].cached = 1; vecs[3].path = 1; vecs[3].size = 3; vecs[3].addr = 48'h100;
        vecs[3].n_rbeats = 4;
        vecs[3].rbeat = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                         64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
        vecs[3].rresp = {2'b00, 2'b00, 2'b10, 2'b00};
        vecs[3].exp_addr = 48'h100; vecs[3].exp_len = 3; vecs[3].exp_size = 3;
        vecs[3].exp_data = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                            64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
        vecs[3].exp_load_fault = 1; vecs[3].exp_cycles = 7;
        // 4: uncached 8-byte write to lane 1, SLVERR response
        vecs[4].write = 1; vecs[4].path = 1; vecs[4].size = 3; vecs[4].addr = 48'h108;
        vecs[4].strob = 32'h0000_5A00; vecs[4].bresp = RESP_SLVERR;
        vecs[4].wdata = {64'h4, 64'h3, 64'hCAFE_F00D_1234_5678, 64'h1};
        vecs[4].exp_addr = 48'h108; vecs[4].exp_len = 0; vecs[4].exp_size = 3;
        vecs[4].exp_wbeats = 1;
        vecs[4].exp_wdata = {192'h0, 64'hCAFE_F00D_1234_5678};
        vecs[4].exp_strb = {24'h0, 8'h5A};
        vecs[4].exp_store_fault = 1; vecs[4].exp_cycles = 5;
        // 5: cached read with oversize size field, EXOKAY beats
        vecs[5].cached = 1; vecs[5].size = 7; vecs[5].addr = 48'h3F; vecs[5].n_rbeats = 4;
        vecs[5].rbeat = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                         64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
        vecs[5].rresp = {2'b01, 2'b01, 2'b01, 2'b01};
        vecs[5].exp_addr = 48'h20; vecs[5].exp_len = 3; vecs[5].exp_size = 3;
        vecs[5].exp_data = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                            64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
        vecs[5].exp_cycles = 7;
        // 6: cached read ended early by r_last on beat 1
        vecs[6].cached = 1; vecs[6].path = 1; vecs[6].size = 3; vecs[6].addr = 48'h80;
        vecs[6].n_rbeats = 2;
        vecs[6].rbeat = {128'h0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h9999_9999_9999_9999};
        vecs[6].exp_addr = 48'h80; vecs[6].exp_len = 3; vecs[6].exp_size = 3;
        vecs[6].exp_data = {128'h0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h9999_9999_9999_9999};
        vecs[6].exp_cycles = 5;
    endtask

    task automatic applyStimulus(input int idx);
        vec_t v;
        int   cyc, rb, wb, guard;
        logic wtog, done, seen_ax;
        v = vecs[idx];
        @(negedge i_clk);
        guard = 0;
        while (!o_req_mem_ready && guard < 20) begin
            @(negedge i_clk);
            guard++;
        end
        checkOutput("req_ready_idle", o_req_mem_ready, 1);
        i_req_mem_valid = 1'b1;
        i_req_mem_path  = v.path;
        i_req_mem_type  = {1'b0, v.cached, v.write};
        i_req_mem_size  = v.size;
        i_req_mem_addr  = v.addr;
        i_req_mem_strob = v.strob;
        i_req_mem_data  = v.wdata;
        @(negedge i_clk);
        i_req_mem_valid = 1'b0;
        cyc = 1; rb = 0; wb = 0; wtog = 1'b0; done = 1'b0; seen_ax = 1'b0;
        while (!done && cyc < 40) begin
            clearSlave();
            if ((o_ar_valid || o_aw_valid) && !seen_ax) begin
                seen_ax = 1'b1;
                checkOutput("ax_latency", cyc, 1);
                checkOutput("ax_channel_sel", {o_ar_valid, o_aw_valid}, v.write ? 2'b01 : 2'b10);
                if (v.write) begin
                    checkOutput("w_valid_before_aw", o_w_valid, 0);
                    checkOutput("aw_addr", o_aw_addr, v.exp_addr);
                    checkOutput("aw_len", o_aw_len, v.exp_len);
                    checkOutput("aw_size", o_aw_size, v.exp_size);
                    checkOutput("aw_burst", o_aw_burst, BURST_INCR);
                end else begin
                    checkOutput("ar_addr", o_ar_addr, v.exp_addr);
                    checkOutput("ar_len", o_ar_len, v.exp_len);
                    checkOutput("ar_size", o_ar_size, v.exp_size);
                    checkOutput("ar_burst", o_ar_burst, BURST_INCR);
                end
            end
            i_ar_ready = o_ar_valid;
            i_aw_ready = o_aw_valid;
            if (o_r_ready) begin
                i_r_valid = 1'b1;
                if (rb < 4) begin
                    i_r_data = v.rbeat[rb];
                    i_r_resp = v.rresp[rb];
                end
                i_r_last = (rb >= v.n_rbeats - 1);
                rb++;
            end
            if (o_w_valid) begin
                checkOutput("w_beat_in_range", wb < v.exp_wbeats, 1);
                if (wb < 4) begin
                    checkOutput("w_data", o_w_data, v.exp_wdata[wb]);
                    checkOutput("w_strb", o_w_strb, v.exp_strb[wb]);
                    checkOutput("w_last", o_w_last, wb == v.exp_wbeats - 1);
                end
                i_w_ready = v.wtoggle ? wtog : 1'b1;
                wtog = ~wtog;
                if (i_w_ready) wb++;
            end
            if (o_b_ready) begin
                i_b_valid = 1'b1;
                i_b_resp  = v.bresp;
            end
            if (o_resp_mem_valid) begin
                done = 1'b1;
                checkOutput("resp_data", o_resp_mem_data, v.exp_data);
                checkOutput("resp_path", o_resp_mem_path, v.path);
                checkOutput("resp_load_fault", o_resp_mem_load_fault, v.exp_load_fault);
                checkOutput("resp_store_fault", o_resp_mem_store_fault, v.exp_store_fault);
                checkOutput("req_ready_in_resp", o_req_mem_ready, 0);
                checkOutput("r_beats_taken", rb, v.n_rbeats);
                checkOutput("w_beats_sent", wb, v.exp_wbeats);
                if (v.exp_cycles != 0) checkOutput("round_trip_cycles", cyc + 1, v.exp_cycles);
            end
            @(negedge i_clk);
            cyc++;
        end
        clearSlave();
        checkOutput("resp_seen", done, 1);
        checkOutput("resp_one_cycle", o_resp_mem_valid, 0);
        checkOutput("ready_after_resp", o_req_mem_ready, 1);
    endtask

    initial begin
        int   guard;
        logic got, busy_ready, late_resp;
        checks = 0;
        errors = 0;
        i_rst = 1'b1;
        i_req_mem_valid = 1'b0;
        i_req_mem_path  = 1'b0;
        i_req_mem_type  = '0;
        i_req_mem_size  = '0;
        i_req_mem_addr  = '0;
        i_req_mem_strob = '0;
        i_req_mem_data  = '0;
        clearSlave();
        fillVectors();
        repeat (3) @(negedge i_clk);

        checkOutput("rst_req_ready", o_req_mem_ready, 1);
        checkOutput("rst_valids", {o_ar_valid, o_aw_valid, o_w_valid, o_r_ready, o_b_ready, o_resp_mem_valid}, 0);
        checkOutput("rst_resp_data", o_resp_mem_data, 0);
        checkOutput("rst_faults_path", {o_resp_mem_load_fault, o_resp_mem_store_fault, o_resp_mem_path}, 0);
        i_rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(i);
        end

        $display("[TB] back-to-back requests");
        @(negedge i_clk);
        i_req_mem_valid = 1'b1;
        i_req_mem_path  = 1'b0;
        i_req_mem_type  = 3'b000;
        i_req_mem_size  = 3'd3;
        i_req_mem_addr  = 48'h8;
        checkOutput("b2b_first_ready", o_req_mem_ready, 1);
        @(negedge i_clk);
        i_req_mem_addr = 48'h10;
        got = 1'b0; busy_ready = 1'b0; guard = 0;
        while (!got && guard < 20) begin
            slaveStep(64'h1234);
            if (o_resp_mem_valid) begin
                got = 1'b1;
                checkOutput("b2b_first_data", o_resp_mem_data, {128'h0, 64'h1234, 64'h0});
            end
            if (o_req_mem_ready) busy_ready = 1'b1;
            @(negedge i_clk);
            guard++;
        end
        clearSlave();
        checkOutput("b2b_first_resp", got, 1);
        checkOutput("b2b_ready_while_busy", busy_ready, 0);
        checkOutput("b2b_ready_after_resp", o_req_mem_ready, 1);
        @(negedge i_clk);
        i_req_mem_valid = 1'b0;
        checkOutput("b2b_second_ar_valid", o_ar_valid, 1);
        checkOutput("b2b_second_ar_addr", o_ar_addr, 48'h10);
        got = 1'b0; guard = 0;
        while (!got && guard < 20) begin
            slaveStep(64'h5678);
            if (o_resp_mem_valid) begin
                got = 1'b1;
                checkOutput("b2b_second_data", o_resp_mem_data, {64'h0, 64'h5678, 128'h0});
            end
            @(negedge i_clk);
            guard++;
        end
        clearSlave();
        checkOutput("b2b_second_resp", got, 1);

        $display("[TB] reset during write burst");
        @(negedge i_clk);
        i_req_mem_valid = 1'b1;
        i_req_mem_path  = 1'b1;
        i_req_mem_type  = 3'b011;
        i_req_mem_addr  = 48'h40;
        i_req_mem_strob = 32'hFFFF_FFFF;
        i_req_mem_data  = {4{64'h0F0F_0F0F_0F0F_0F0F}};
        @(negedge i_clk);
        i_req_mem_valid = 1'b0;
        slaveStep(64'h0);
        @(negedge i_clk);
        slaveStep(64'h0);
        checkOutput("rst_w_beat0_valid", o_w_valid, 1);
        @(negedge i_clk);
        slaveStep(64'h0);
        checkOutput("rst_w_beat1_valid", o_w_valid, 1);
        @(negedge i_clk);
        clearSlave();
        checkOutput("rst_still_in_w", o_w_valid, 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        checkOutput("rst_abort_valids", {o_ar_valid, o_aw_valid, o_w_valid, o_r_ready, o_b_ready, o_resp_mem_valid}, 0);
        checkOutput("rst_abort_ready", o_req_mem_ready, 1);
        late_resp = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            if (o_resp_mem_valid) late_resp = 1'b1;
        end
        checkOutput("rst_abort_no_resp", late_resp, 0);
        applyStimulus(0);

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
